// File: rtl/regex_pc_fifo.sv
// Purpose: ordered (cc_id, pc) thread-record buffer with per-cc_id occupancy flags.
// Latency: 1 cycle push-to-head (0 when REGEX_PC_FIFO_BYPASS_EN is defined and the FIFO is empty).
// Backpressure: in_pc_ready = !full & !flush; a push into a full FIFO is refused even if it pops that cycle.
module regex_pc_fifo #(
  parameter int PC_WIDTH        = 9,
  parameter int CC_ID_BITS      = 2,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_pc_valid,
  input  logic [CC_ID_BITS-1:0]        in_cc_id,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         in_pc_ready,
  output logic                         out_pc_valid,
  output logic [CC_ID_BITS-1:0]        out_cc_id,
  output logic [PC_WIDTH-1:0]          out_pc,
  input  logic                         out_pc_ready,
  output logic [FIFO_DEPTH_BITS:0]     count,
  output logic [(1<<CC_ID_BITS)-1:0]   cc_pending
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int NCC   = 1 << CC_ID_BITS;
  localparam int CNT_W = FIFO_DEPTH_BITS + 1;

  typedef struct packed {
    logic [CC_ID_BITS-1:0] cc_id;
    logic [PC_WIDTH-1:0]   pc;
  } rec_t;

  rec_t                       mem [DEPTH];
  rec_t                       in_rec, head, out_rec, hold_q;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cc_cnt [NCC];
  logic [NCC-1:0]             cc_inc, cc_dec;
  logic                       full, empty, head_vld;
  logic                       push, pop, wr_en, rd_en;

  assign in_rec   = '{cc_id: in_cc_id, pc: in_pc};
  assign head     = mem[rd_ptr];
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_vld = rst && !empty && !flush;

  assign in_pc_ready = rst && !full && !flush;
  assign push        = in_pc_valid && in_pc_ready;
  assign pop         = out_pc_valid && out_pc_ready;
  assign rd_en       = pop && !empty;

`ifdef REGEX_PC_FIFO_BYPASS_EN
  logic byp;
  always_comb begin
    byp          = rst && empty && !flush;
    out_pc_valid = head_vld || (byp && in_pc_valid);
    out_rec      = head_vld ? head : ((byp && in_pc_valid) ? in_rec : hold_q);
    // A record taken straight through never touches storage or the counters.
    wr_en        = push && !(byp && out_pc_ready);
  end
`else
  always_comb begin
    out_pc_valid = head_vld;
    out_rec      = head_vld ? head : hold_q;
    wr_en        = push;
  end
`endif

  assign out_cc_id = out_rec.cc_id;
  assign out_pc    = out_rec.pc;
  assign count     = cnt_q;

  always_comb begin
    cc_inc     = '0;
    cc_dec     = '0;
    cc_pending = '0;
    for (int i = 0; i < NCC; i++) begin
      cc_inc[i]     = wr_en && (in_cc_id == CC_ID_BITS'(i));
      cc_dec[i]     = rd_en && (head.cc_id == CC_ID_BITS'(i));
      cc_pending[i] = rst && (cc_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NCC; i++) cc_cnt[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NCC; i++) cc_cnt[i] <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (rd_en) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      if (wr_en && !rd_en)      cnt_q <= cnt_q + CNT_W'(1);
      else if (rd_en && !wr_en) cnt_q <= cnt_q - CNT_W'(1);
      for (int i = 0; i < NCC; i++) begin
        if (cc_inc[i] && !cc_dec[i])      cc_cnt[i] <= cc_cnt[i] + CNT_W'(1);
        else if (cc_dec[i] && !cc_inc[i]) cc_cnt[i] <= cc_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Last presented head, shown while nothing is valid so out_* never goes X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              hold_q <= '0;
    else if (out_pc_valid) hold_q <= out_rec;
  end

`ifndef SYNTHESIS
  int cc_sum;
  always_comb begin
    cc_sum = 0;
    for (int i = 0; i < NCC; i++) cc_sum += int'(cc_cnt[i]);
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(wr_en && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(rd_en && empty));
  a_cc_sum:       assert property (@(posedge clk) disable iff (!rst) cc_sum == int'(cnt_q));
`endif

endmodule

// File: tb/tb_regex_pc_fifo.sv
// Directed bench for regex_pc_fifo: ordering, full/wrap, flush, reset and push-to-head latency.
module tb_regex_pc_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, in_pc_valid, out_pc_ready;
  logic [1:0] in_cc_id, out_cc_id;
  logic [8:0] in_pc, out_pc;
  logic       in_pc_ready, out_pc_valid;
  logic [4:0] count;
  logic [3:0] cc_pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regex_pc_fifo #(.PC_WIDTH(9), .CC_ID_BITS(2), .FIFO_DEPTH_BITS(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_pc_valid(in_pc_valid), .in_cc_id(in_cc_id), .in_pc(in_pc), .in_pc_ready(in_pc_ready),
    .out_pc_valid(out_pc_valid), .out_cc_id(out_cc_id), .out_pc(out_pc), .out_pc_ready(out_pc_ready),
    .count(count), .cc_pending(cc_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_pc_valid  = 1'b0;
    out_pc_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_pc_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_pc_ready); end
    total++; if (out_pc_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_pc_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (cc_pending !== 4'b0000) begin bad++; $display("FAIL rst_cc_pending got=%b exp=0000", cc_pending); end
    tick();
    rst = 1'b1;
    #1;
    total++; if (in_pc_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_pc_ready); end
    total++; if (out_pc_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid got=%b exp=0", out_pc_valid); end
  endtask

  task automatic test_order();
    tick();
    out_pc_ready = 1'b0;
    in_pc_valid = 1'b1; in_cc_id = 2'd1; in_pc = 9'h062;
    tick();
    in_cc_id = 2'd3; in_pc = 9'h063;
    tick();
    in_pc_valid = 1'b0;
    #1;
    total++; if (count !== 5'd2) begin bad++; $display("FAIL order_count got=%0d exp=2", count); end
    total++; if (cc_pending !== 4'b1010) begin bad++; $display("FAIL order_pending got=%b exp=1010", cc_pending); end
    total++; if (out_pc_valid !== 1'b1 || out_cc_id !== 2'd1 || out_pc !== 9'h062)
      begin bad++; $display("FAIL order_head1 got=%b/%0d/%h exp=1/1/062", out_pc_valid, out_cc_id, out_pc); end
    out_pc_ready = 1'b1;
    tick();
    total++; if (out_pc_valid !== 1'b1 || out_cc_id !== 2'd3 || out_pc !== 9'h063)
      begin bad++; $display("FAIL order_head2 got=%b/%0d/%h exp=1/3/063", out_pc_valid, out_cc_id, out_pc); end
    tick();
    out_pc_ready = 1'b0;
    #1;
    total++; if (count !== 5'd0 || out_pc_valid !== 1'b0) begin bad++; $display("FAIL order_drained got=%0d/%b exp=0/0", count, out_pc_valid); end
    total++; if (out_pc !== 9'h063 || out_cc_id !== 2'd3) begin bad++; $display("FAIL order_hold got=%0d/%h exp=3/063", out_cc_id, out_pc); end
  endtask

  task automatic test_full_wrap();
    logic [8:0] exp_pc;
    logic [1:0] exp_cc;
    out_pc_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_pc_valid = 1'b1; in_cc_id = 2'(i % 4); in_pc = 9'(9'h062 + i);
      tick();
    end
    #1;
    total++; if (in_pc_ready !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL full_state got=%b/%0d exp=0/16", in_pc_ready, count); end
    total++; if (cc_pending !== 4'b1111) begin bad++; $display("FAIL full_pending got=%b exp=1111", cc_pending); end
    in_cc_id = 2'd0; in_pc = 9'h072; out_pc_ready = 1'b1;
    #1;
    total++; if (in_pc_ready !== 1'b0) begin bad++; $display("FAIL full_refuse got=%b exp=0", in_pc_ready); end
    tick();
    out_pc_ready = 1'b0;
    #1;
    total++; if (in_pc_ready !== 1'b1 || count !== 5'd15) begin bad++; $display("FAIL full_after_pop got=%b/%0d exp=1/15", in_pc_ready, count); end
    tick();
    in_pc_valid = 1'b0;
    #1;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_17th_count got=%0d exp=16", count); end
    out_pc_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      exp_pc = 9'(9'h062 + i);
      exp_cc = 2'(i % 4);
      total++; if (out_pc_valid !== 1'b1 || out_cc_id !== exp_cc || out_pc !== exp_pc)
        begin bad++; $display("FAIL wrap_order[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, out_pc_valid, out_cc_id, out_pc, exp_cc, exp_pc); end
      tick();
    end
    out_pc_ready = 1'b0;
    #1;
    total++; if (count !== 5'd0 || cc_pending !== 4'b0000) begin bad++; $display("FAIL wrap_drained got=%0d/%b exp=0/0000", count, cc_pending); end
  endtask

  task automatic test_push_pop_same();
    in_pc_valid = 1'b1; in_cc_id = 2'd2; in_pc = 9'h0A0;
    tick();
    in_pc = 9'h0A1; out_pc_ready = 1'b1;
    #1;
    total++; if (out_cc_id !== 2'd2 || out_pc !== 9'h0A0) begin bad++; $display("FAIL pp_head_before got=%0d/%h exp=2/0a0", out_cc_id, out_pc); end
    tick();
    idle();
    #1;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL pp_count got=%0d exp=1", count); end
    total++; if (cc_pending !== 4'b0100) begin bad++; $display("FAIL pp_pending got=%b exp=0100", cc_pending); end
    total++; if (out_pc_valid !== 1'b1 || out_cc_id !== 2'd2 || out_pc !== 9'h0A1)
      begin bad++; $display("FAIL pp_head_after got=%b/%0d/%h exp=1/2/0a1", out_pc_valid, out_cc_id, out_pc); end
    out_pc_ready = 1'b1;
    tick();
    out_pc_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      in_pc_valid = 1'b1; in_cc_id = 2'(i % 4); in_pc = 9'(9'h0C0 + i);
      tick();
    end
    in_pc_valid = 1'b0;
    #1;
    total++; if (count !== 5'd5 || cc_pending !== 4'b1111) begin bad++; $display("FAIL flush_pre got=%0d/%b exp=5/1111", count, cc_pending); end
    flush = 1'b1; in_pc_valid = 1'b1; in_cc_id = 2'd1; in_pc = 9'h0F0; out_pc_ready = 1'b1;
    #1;
    total++; if (in_pc_ready !== 1'b0 || out_pc_valid !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b/%b exp=0/0", in_pc_ready, out_pc_valid); end
    tick();
    idle();
    #1;
    total++; if (count !== 5'd0 || cc_pending !== 4'b0000 || out_pc_valid !== 1'b0)
      begin bad++; $display("FAIL flush_post got=%0d/%b/%b exp=0/0000/0", count, cc_pending, out_pc_valid); end
  endtask

  task automatic test_latency();
    in_pc_valid = 1'b1; in_cc_id = 2'd0; in_pc = 9'h108; out_pc_ready = 1'b1;
    #1;
`ifdef REGEX_PC_FIFO_BYPASS_EN
    total++; if (out_pc_valid !== 1'b1 || out_pc !== 9'h108 || out_cc_id !== 2'd0)
      begin bad++; $display("FAIL lat_same_cycle got=%b/%0d/%h exp=1/0/108", out_pc_valid, out_cc_id, out_pc); end
    tick();
    idle();
    #1;
    total++; if (count !== 5'd0 || out_pc_valid !== 1'b0) begin bad++; $display("FAIL lat_bypass_post got=%0d/%b exp=0/0", count, out_pc_valid); end
`else
    total++; if (out_pc_valid !== 1'b0) begin bad++; $display("FAIL lat_same_cycle got=%b exp=0", out_pc_valid); end
    tick();
    idle();
    #1;
    total++; if (count !== 5'd1 || out_pc_valid !== 1'b1 || out_cc_id !== 2'd0 || out_pc !== 9'h108)
      begin bad++; $display("FAIL lat_next_cycle got=%0d/%b/%0d/%h exp=1/1/0/108", count, out_pc_valid, out_cc_id, out_pc); end
    out_pc_ready = 1'b1;
    tick();
    out_pc_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in_pc_valid = 1'b1; in_cc_id = 2'(i); in_pc = 9'(9'h050 + i);
      tick();
    end
    #1;
    total++; if (count !== 5'd3) begin bad++; $display("FAIL rmid_pre got=%0d exp=3", count); end
    rst = 1'b0;
    #1;
    total++; if (in_pc_ready !== 1'b0 || out_pc_valid !== 1'b0) begin bad++; $display("FAIL rmid_gate got=%b/%b exp=0/0", in_pc_ready, out_pc_valid); end
    total++; if (count !== 5'd0 || cc_pending !== 4'b0000) begin bad++; $display("FAIL rmid_clear got=%0d/%b exp=0/0000", count, cc_pending); end
    tick();
    in_pc_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (in_pc_ready !== 1'b1 || out_pc_valid !== 1'b0) begin bad++; $display("FAIL rmid_release got=%b/%b exp=1/0", in_pc_ready, out_pc_valid); end
  endtask

  initial begin
    rst = 1'b1;
    in_cc_id = '0;
    in_pc = '0;
    idle();
    #1 rst = 1'b0;
    test_reset();
    test_order();
    test_full_wrap();
    test_push_pop_same();
    test_flush();
    test_latency();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
